// File: rtl/skid_buffer_pkg.sv
// Shared types for the skid buffer.
package skid_buffer_pkg;
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} skid_state_t;
endpackage

// File: rtl/skid_buffer_register_slice.sv
// Enable-gated data register with synchronous reset to a fixed word.
module register_slice #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);
    localparam logic [DATA_WIDTH-1:0] RESET_WORD = DATA_WIDTH'(RESET_VALUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_WORD;
        end else if (clk_en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/skid_buffer.sv
// Registered valid/ready stage: main output register plus one skid register.
// States:  EMPTY | nothing held          BUSY | main holds a word
//          FULL  | main and skid hold words, upstream back-pressured
module skid_buffer
    import skid_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);
    skid_state_t           state;
    logic                  in_fire;
    logic                  out_fire;
    logic                  main_load;
    logic                  skid_load;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] skid_q;

    assign in_fire  = data_in_valid & data_in_ready;
    assign out_fire = data_out_valid & data_out_ready;

    always_comb begin
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = data_in;
        case (state)
            EMPTY: main_load = in_fire;
            BUSY: begin
                main_load = in_fire & out_fire;
                skid_load = in_fire & ~out_fire;
            end
            FULL: begin
                main_load = out_fire;
                main_d    = skid_q;
            end
            default: ;
        endcase
    end

    register_slice #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_VALUE(RESET_VALUE)
    ) u_main (
        .clk   (clk),
        .rst   (rst),
        .clk_en(main_load),
        .d     (main_d),
        .q     (data_out)
    );

    register_slice #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_VALUE(RESET_VALUE)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clk_en(skid_load),
        .d     (data_in),
        .q     (skid_q)
    );

    // Handshake outputs are registered alongside the state so that
    // data_in_ready never sees data_out_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= EMPTY;
            data_out_valid <= 1'b0;
            data_in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state          <= BUSY;
                        data_out_valid <= 1'b1;
                        data_in_ready  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (in_fire && !out_fire) begin
                        state          <= FULL;
                        data_out_valid <= 1'b1;
                        data_in_ready  <= 1'b0;
                    end else if (!in_fire && out_fire) begin
                        state          <= EMPTY;
                        data_out_valid <= 1'b0;
                        data_in_ready  <= 1'b1;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state          <= BUSY;
                        data_out_valid <= 1'b1;
                        data_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state          <= EMPTY;
                    data_out_valid <= 1'b0;
                    data_in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_skid_buffer.sv
// Scoreboard bench for skid_buffer: directed scenarios plus random stress.
module tb_skid_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic        data_in_ready;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready = 1'b0;

    logic [7:0]  s_data_in = '0;
    logic        s_data_in_valid = 1'b0;
    logic        s_data_in_ready;
    logic [7:0]  s_data_out;
    logic        s_data_out_valid;
    logic        s_data_out_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    int occ = 0;

    skid_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
    );

    skid_buffer #(.DATA_WIDTH(8), .RESET_VALUE('h1A5)) dut_small (
        .clk           (clk),
        .rst           (rst),
        .data_in       (s_data_in),
        .data_in_valid (s_data_in_valid),
        .data_in_ready (s_data_in_ready),
        .data_out      (s_data_out),
        .data_out_valid(s_data_out_valid),
        .data_out_ready(s_data_out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called just after a posedge: sets up the handshake for the next edge
    // and records the word in the scoreboard if it will be accepted.
    task automatic drive(input logic v, input logic [31:0] d, input logic r, output logic acc);
        data_in_valid  = v;
        data_in        = d;
        data_out_ready = r;
        acc = v && data_in_ready && !rst;
        if (acc) exp_q.push_back(d);
    endtask

    // Reference model: a word occupancy count and the FIFO of accepted words.
    always @(negedge clk) begin
        if (rst) begin
            occ = 0;
        end else begin
            check("valid_vs_model", 32'(data_out_valid), 32'(occ > 0));
            check("ready_vs_model", 32'(data_in_ready), 32'(occ < 2));
            if (data_out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", data_out, $time);
                end else begin
                    check("data_order", data_out, exp_q[0]);
                    if (data_out_ready) void'(exp_q.pop_front());
                end
            end
            occ = occ + ((data_in_valid && data_in_ready) ? 1 : 0)
                      - ((data_out_valid && data_out_ready) ? 1 : 0);
        end
    end

    a_stable: assert property (@(posedge clk) disable iff (rst)
        (data_out_valid && !data_out_ready) |=> $stable(data_out))
        else begin
            errors++;
            $display("FAIL stall_stability: data_out changed to %0h while stalled", data_out);
        end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        logic r0;
        logic [31:0] word;
        int sent;
        int cycles;

        cyc();
        cyc();
        rst = 1'b0;
        check("reset_valid", 32'(data_out_valid), 32'd0);
        check("reset_ready", 32'(data_in_ready), 32'd1);
        check("reset_data", data_out, 32'd0);
        check("small_reset_data", 32'(s_data_out), 32'h0A5);
        check("small_reset_valid", 32'(s_data_out_valid), 32'd0);

        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 1'b1, acc);
            check("stream_accept", 32'(acc), 32'd1);
            cyc();
            check("stream_latency", data_out, 32'(i));
        end
        drive(1'b0, '0, 1'b1, acc);
        repeat (3) cyc();

        drive(1'b1, 32'hA, 1'b0, acc);
        cyc();
        drive(1'b1, 32'hB, 1'b0, acc);
        cyc();
        check("stall_ready_low", 32'(data_in_ready), 32'd0);
        check("stall_hold_a", data_out, 32'hA);
        drive(1'b0, '0, 1'b0, acc);
        cyc();
        check("stall_still_a", data_out, 32'hA);
        drive(1'b0, '0, 1'b1, acc);
        cyc();
        check("stall_then_b", data_out, 32'hB);
        check("stall_ready_back", 32'(data_in_ready), 32'd1);
        cyc();
        check("stall_drained", 32'(data_out_valid), 32'd0);

        drive(1'b1, 32'h11, 1'b0, acc);
        cyc();
        drive(1'b1, 32'h22, 1'b0, acc);
        cyc();
        check("midrst_full", 32'(data_in_ready), 32'd0);
        rst = 1'b1;
        data_in_valid = 1'b0;
        exp_q.delete();
        cyc();
        rst = 1'b0;
        check("midrst_valid", 32'(data_out_valid), 32'd0);
        check("midrst_ready", 32'(data_in_ready), 32'd1);
        check("midrst_data", data_out, 32'd0);
        drive(1'b0, '0, 1'b1, acc);
        repeat (4) cyc();

        sent = 0;
        cycles = 0;
        word = $urandom;
        while (sent < 10000 && cycles < 60000) begin
            drive(1'($urandom_range(0, 1)), word, 1'($urandom_range(0, 1)), acc);
            if (acc) begin
                sent++;
                word = $urandom;
            end
            if (cycles % 64 == 0) begin
                r0 = data_in_ready;
                data_out_ready = ~data_out_ready;
                #1;
                check("ready_no_comb_path", 32'(data_in_ready), 32'(r0));
                data_out_ready = ~data_out_ready;
            end
            cyc();
            cycles++;
        end
        check("random_words_sent", 32'(sent), 32'd10000);

        drive(1'b0, '0, 1'b1, acc);
        repeat (5) cyc();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(data_out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/skid_buffer.md
Name: skid_buffer

Overview:
- Valid/ready pipeline stage that decouples an upstream producer from a downstream consumer in the streaming datapath.
- Registers both the forward path (data/valid) and the backward path (ready).
- Sustains 1 transfer/cycle with no combinational path from data_out_ready to data_in_ready.
- Holds up to two words: a main output register plus one skid register that catches the in-flight word when downstream stalls.

Parameters:
- DATA_WIDTH, 32, width of each transferred word.
- RESET_VALUE, 0, value of both data registers after reset; truncated to DATA_WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH  upstream word.
- data_in_valid  input  1  upstream word valid.
- data_in_ready  output  1  buffer can accept; registered.
- data_out  output  DATA_WIDTH  downstream word; driven directly from the main register.
- data_out_valid  output  1  data_out valid; registered.
- data_out_ready  input  1  downstream accepts.

Behaviour:
- Transfer definitions:
  - in_fire = data_in_valid & data_in_ready.
  - out_fire = data_out_valid & data_out_ready.
- Reset, sampled on posedge clk when rst=1:
  - state=EMPTY, main=skid=RESET_VALUE.
  - data_out=RESET_VALUE, data_out_valid=0, data_in_ready=1.
  - All handshakes in the reset cycle are ignored.
  - Reset mid-operation discards all held words.
- States (data_out_valid / data_in_ready):
  - EMPTY: 0 / 1.
  - BUSY (main valid): 1 / 1.
  - FULL (main+skid valid): 1 / 0.
- Transitions:
  - EMPTY: in_fire -> BUSY, main<=data_in. Else stay.
  - BUSY, in_fire & out_fire -> BUSY, main<=data_in.
  - BUSY, in_fire & !out_fire -> FULL, skid<=data_in.
  - BUSY, !in_fire & out_fire -> EMPTY.
  - BUSY, otherwise -> stay.
  - FULL: out_fire -> BUSY, main<=skid. Else stay. in_fire is impossible in FULL.
- Latency: a word accepted at edge N is on data_out with data_out_valid=1 after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle while data_out_ready=1.
- Ordering: strict FIFO order; no drop, no duplication.
- Stability: while data_out_valid=1 and data_out_ready=0, data_out must not change.
- Data registers load only on their load enable; otherwise they hold. No toggling on idle cycles.
- data_in_valid=1 while data_in_ready=0 is ignored. Upstream is responsible for holding the word.
- data_out_ready toggling while data_out_valid=0 has no effect.
- data_in_ready and data_out_valid are pure functions of the registered state.

Decomposition:
- Package skid_buffer_pkg:
  - typedef enum logic [1:0] skid_state_t {EMPTY, BUSY, FULL}.
  - Nothing else.
- Sub-module: main and skid data registers each instantiate the existing register_slice.
  - clk_en = that register's load enable.
  - RESET_VALUE passed through.
- Control FSM stays in skid_buffer.

Test Plan:
- Reset with rst=1 for 2 cycles, then released → data_out_valid=0, data_in_ready=1, data_out=RESET_VALUE.
- Streaming: data_out_ready=1, drive 0x1..0x8 back-to-back → data_out shows 0x1..0x8 on consecutive cycles, each 1 cycle after acceptance, with no bubbles.
- Stall: send 0xA, 0xB on consecutive cycles while data_out_ready=0.
  - Expect data_in_ready=0 after 0xB, and data_out held at 0xA.
  - Raise data_out_ready → 0xA then 0xB, with data_in_ready back to 1 one cycle after 0xA leaves.
- Random stress: random data_in_valid and data_out_ready at 50% each, 10k words.
  - Scoreboard checks exact order with no loss or duplication.
  - Assertions: data_out stable during stall; data_in_ready never combinationally depends on data_out_ready.
- Mid-operation reset: reach FULL holding 0x11, 0x22, assert rst for 1 cycle → data_out_valid=0, data_in_ready=1, and neither word is ever emitted.
- Width and reset value: DATA_WIDTH=8, RESET_VALUE=0x1A5 → data_out=0xA5 after reset.
